decade_stream_monitor: RTL

- Receive-side checker for the decade counter interface: enable `x`, BCD count `Q[3:0]`, carry `z`.
- Samples the stream every clock and locks onto the count sequence. Flags illegal codes, sequence breaks and carry mismatches.
- Tallies completed decades in a 2-digit BCD accumulator.
- Sits beside the counter in the lab top level; its outputs drive LEDs and 7-segment display logic.

---
 rtl/decade_pkg.sv | 31 +++
 rtl/decade_stream_monitor_bcd_tally2.sv | 36 +++
 rtl/decade_stream_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/decade_pkg.sv
// Shared definitions for the decade counter stream monitor: digit limit,
// violation codes, monitor state encoding and a single-digit BCD step helper.
package decade_pkg;

  localparam logic [3:0] DEC_MAX = 4'd9;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_SEQ     = 2'b10;
  localparam logic [1:0] ERR_CARRY   = 2'b11;

  typedef enum logic [1:0] {
    S_HUNT  = 2'b00,
    S_TRACK = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  typedef struct packed {
    logic       wrap;
    logic [3:0] val;
  } bcd_step_t;

  // One BCD digit increment: 9 wraps to 0 and reports the carry out.
  function automatic bcd_step_t bcd_next(input logic [3:0] d);
    bcd_step_t s;
    s.wrap = (d == DEC_MAX);
    s.val  = s.wrap ? 4'd0 : d + 4'd1;
    return s;
  endfunction

endpackage

// File: rtl/decade_stream_monitor_bcd_tally2.sv
// Two-digit BCD event tally with a sticky flag raised when it wraps 99 -> 00.
module bcd_tally2
  import decade_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  output logic [7:0] o_value,
  output logic       o_ovf
);

  logic [7:0] r_value;
  logic       r_ovf;
  bcd_step_t  w_ones;
  bcd_step_t  w_tens;

  assign w_ones  = bcd_next(r_value[3:0]);
  assign w_tens  = bcd_next(r_value[7:4]);
  assign o_value = r_value;
  assign o_ovf   = r_ovf;

  // Ripple the ones-digit carry into tens; a tens carry marks the overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value <= 8'h00;
      r_ovf   <= 1'b0;
    end else if (i_en) begin
      r_value[3:0] <= w_ones.val;
      if (w_ones.wrap) begin
        r_value[7:4] <= w_tens.val;
        if (w_tens.wrap) r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/decade_stream_monitor.sv
// Receive-side checker for a decade counter stream (enable x, BCD count,
// carry). Locks onto the count sequence, reports violations and tallies
// completed decades while tracking.
module decade_stream_monitor
  import decade_pkg::*;
#(
  parameter int LOCK_CNT   = 2,
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  input  logic [3:0] q_in,
  input  logic       z_in,
  output logic       locked,
  output logic       err,
  output logic [1:0] err_code,
  output logic       fault,
  output logic [7:0] decades,
  output logic       tally_ovf
);

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_CNT);

  state_t     r_state;
  logic       r_have_hist;
  logic [2:0] r_match_cnt;
  logic [3:0] r_prev_q;
  logic       r_prev_x;
  logic       r_locked;
  logic       r_fault;
  logic       r_err;
  logic [1:0] r_err_code;

  logic [3:0] w_exp;
  logic       w_ill;
  logic       w_seq;
  logic       w_car;
  logic       w_viol;
  logic       w_tally_en;
  logic [1:0] w_code;

  // Expected sample: advance (wrapping 9 -> 0) if the counter was enabled, else hold.
  assign w_exp = r_prev_x ? ((r_prev_q == DEC_MAX) ? 4'd0 : r_prev_q + 4'd1) : r_prev_q;

  assign w_ill  = (q_in > DEC_MAX);
  assign w_seq  = ((r_state == S_TRACK) || ((r_state == S_HUNT) && r_have_hist))
                  && (q_in != w_exp);
  assign w_car  = (z_in != (x & (q_in == DEC_MAX)));
  assign w_viol = w_ill | w_seq | w_car;

  // Only clean carry pulses seen while tracking count as a completed decade.
  assign w_tally_en = (r_state == S_TRACK) & ~w_viol & z_in;

  // Highest-priority violation selects the reported code.
  always_comb begin
    w_code = ERR_NONE;
    if (w_ill)      w_code = ERR_ILLEGAL;
    else if (w_seq) w_code = ERR_SEQ;
    else if (w_car) w_code = ERR_CARRY;
  end

  // Monitor state machine with registered status outputs and sample history.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_have_hist <= 1'b0;
      r_match_cnt <= 3'd0;
      r_prev_q    <= 4'd0;
      r_prev_x    <= 1'b0;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_prev_q <= q_in;
      r_prev_x <= x;
      r_err    <= w_viol;
      if (w_viol) r_err_code <= w_code;
      case (r_state)
        S_HUNT: begin
          r_have_hist <= 1'b1;
          if (!r_have_hist || w_viol) begin
            r_match_cnt <= 3'd0;
          end else if (r_match_cnt + 3'd1 == LOCK_TGT) begin
            r_match_cnt <= 3'd0;
            r_state     <= S_TRACK;
            r_locked    <= 1'b1;
          end else begin
            r_match_cnt <= r_match_cnt + 3'd1;
          end
        end
        S_TRACK: begin
          if (w_viol) begin
            r_state  <= S_FAULT;
            r_locked <= 1'b0;
            r_fault  <= 1'b1;
          end
        end
        S_FAULT: begin
          // Non-sticky recovery: this sample becomes the first capture of a new hunt.
          if (!STICKY_ERR) begin
            r_state     <= S_HUNT;
            r_fault     <= 1'b0;
            r_have_hist <= 1'b1;
            r_match_cnt <= 3'd0;
          end
        end
        default: begin
          r_state     <= S_HUNT;
          r_have_hist <= 1'b0;
          r_match_cnt <= 3'd0;
          r_locked    <= 1'b0;
          r_fault     <= 1'b0;
        end
      endcase
    end
  end

  bcd_tally2 u_tally (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_en    (w_tally_en),
    .o_value (decades),
    .o_ovf   (tally_ovf)
  );

  assign locked   = r_locked;
  assign fault    = r_fault;
  assign err      = r_err;
  assign err_code = r_err_code;

endmodule
